// File: rtl/lsu_pkt_pipe_pkg.sv
// Stage geometry and small helpers for the LSU packet staging pipe.
package lsu_pkt_pipe_pkg;

  localparam int NUM_STAGES    = 5;  // dc1..dc5
  localparam int FREEZE_STAGES = 3;  // dc1..dc3 hold on lsu_freeze_dc3
  localparam int CNT_W         = 3;

  function automatic logic [CNT_W-1:0] count_valid(input logic [NUM_STAGES-1:0] v);
    logic [CNT_W-1:0] n;
    n = '0;
    for (int i = 0; i < NUM_STAGES; i++) n = n + CNT_W'(v[i]);
    return n;
  endfunction

  // Bit k-1 of flush names dck; a flush kills its stage and every younger one,
  // so the oldest asserted flush governs the kill mask.
  function automatic logic [NUM_STAGES-1:0] kill_mask(input logic [NUM_STAGES-1:0] flush);
    logic [NUM_STAGES-1:0] m;
    m = '0;
    m[NUM_STAGES-1] = flush[NUM_STAGES-1];
    for (int k = NUM_STAGES - 2; k >= 0; k--) m[k] = flush[k] | m[k+1];
    return m;
  endfunction

endpackage

// File: rtl/swerv_types.sv
// Core-wide LSU packet definition, shared by the LSU staging pipe and the
// LSU clock-enable block.
package swerv_types;

  typedef struct packed {
    logic valid;
    logic load;
    logic store;
    logic by;
    logic half;
    logic word;
    logic unsign;
    logic dma;
  } lsu_pkt_t;

endpackage

// File: rtl/lsu_pkt_stage.sv
// One LSU pipe stage: packet + address register with hold and kill.
// Kill beats hold; a killed stage drops valid in place and keeps its other fields.
module lsu_pkt_stage
  import swerv_types::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              hold,
  input  logic              kill,
  input  lsu_pkt_t          in_pkt,
  input  logic [ADDR_W-1:0] in_addr,
  output lsu_pkt_t          pkt_q,
  output logic [ADDR_W-1:0] addr_q,
  output logic              valid_d
);

  lsu_pkt_t          pkt_d;
  logic [ADDR_W-1:0] addr_d;

  always_comb begin
    // NOTE: defaults first so every path assigns every signal and no latch is inferred.
    pkt_d  = in_pkt;
    addr_d = in_addr;
    if (kill) begin
      pkt_d       = pkt_q;
      pkt_d.valid = 1'b0;
      addr_d      = addr_q;
    end else if (hold) begin
      pkt_d  = pkt_q;
      addr_d = addr_q;
    end
  end

  assign valid_d = pkt_d.valid;

  always_ff @(posedge clk) begin
    // NOTE: non-blocking updates so every stage samples its neighbour's pre-edge value.
    if (rst) begin
      pkt_q  <= '0;
      addr_q <= '0;
    end else begin
      pkt_q  <= pkt_d;
      addr_q <= addr_d;
    end
  end

endmodule

// File: rtl/lsu_pkt_pipe.sv
// LSU packet/address staging from decode through dc1..dc5 with freeze, flush,
// DMA injection at dc1 and an occupancy count. Runs on the ungated clock.
module lsu_pkt_pipe
  import swerv_types::*;
  import lsu_pkt_pipe_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter bit DMA_EN = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  lsu_pkt_t          lsu_p,
  input  logic [ADDR_W-1:0] lsu_addr_d,
  input  logic              dma_dccm_req,
  input  logic              dma_mem_write,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic              lsu_freeze_dc3,
  input  logic              flush_dc2,
  input  logic              flush_dc3,
  input  logic              flush_dc4,
  input  logic              flush_dc5,
  output lsu_pkt_t          lsu_pkt_dc1,
  output lsu_pkt_t          lsu_pkt_dc2,
  output lsu_pkt_t          lsu_pkt_dc3,
  output lsu_pkt_t          lsu_pkt_dc4,
  output lsu_pkt_t          lsu_pkt_dc5,
  output logic [ADDR_W-1:0] lsu_addr_dc1,
  output logic [ADDR_W-1:0] lsu_addr_dc2,
  output logic [ADDR_W-1:0] lsu_addr_dc3,
  output logic [ADDR_W-1:0] lsu_addr_dc4,
  output logic [ADDR_W-1:0] lsu_addr_dc5,
  output logic [CNT_W-1:0]  lsu_pipe_cnt,
  output logic              lsu_pipe_idle
);

  logic                  dma_sel;
  lsu_pkt_t              src_pkt;
  logic [ADDR_W-1:0]     src_addr;
  lsu_pkt_t              in_pkt    [NUM_STAGES];
  logic [ADDR_W-1:0]     in_addr   [NUM_STAGES];
  lsu_pkt_t              stg_pkt   [NUM_STAGES];
  logic [ADDR_W-1:0]     stg_addr  [NUM_STAGES];
  logic [NUM_STAGES-1:0] hold;
  logic [NUM_STAGES-1:0] kill;
  logic [NUM_STAGES-1:0] nxt_valid;
  logic [CNT_W-1:0]      cnt_d;
  logic [CNT_W-1:0]      cnt_q;

  assign dma_sel = DMA_EN && dma_dccm_req;

  always_comb begin
    src_pkt  = lsu_p;
    src_addr = lsu_addr_d;
    if (dma_sel) begin
      src_pkt       = '0;
      src_pkt.valid = 1'b1;
      src_pkt.dma   = 1'b1;
      src_pkt.word  = 1'b1;
      src_pkt.store = dma_mem_write;
      src_pkt.load  = ~dma_mem_write;
      src_addr      = dma_addr;
    end
  end

  // A frozen dc3 feeds dc4 a zeroed bubble; dc5 always takes dc4.
  always_comb begin
    in_pkt[0]  = src_pkt;
    in_addr[0] = src_addr;
    for (int i = 1; i < NUM_STAGES; i++) begin
      in_pkt[i]  = stg_pkt[i-1];
      in_addr[i] = stg_addr[i-1];
    end
    if (lsu_freeze_dc3) begin
      in_pkt[FREEZE_STAGES]  = '0;
      in_addr[FREEZE_STAGES] = '0;
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_STAGES; i++) hold[i] = (i < FREEZE_STAGES) ? lsu_freeze_dc3 : 1'b0;
  end

  assign kill = kill_mask({flush_dc5, flush_dc4, flush_dc3, flush_dc2, 1'b0});

  for (genvar i = 0; i < NUM_STAGES; i++) begin : g_stage
    lsu_pkt_stage #(.ADDR_W(ADDR_W)) u_stage (
      .clk     (clk),
      .rst     (rst),
      .hold    (hold[i]),
      .kill    (kill[i]),
      .in_pkt  (in_pkt[i]),
      .in_addr (in_addr[i]),
      .pkt_q   (stg_pkt[i]),
      .addr_q  (stg_addr[i]),
      .valid_d (nxt_valid[i])
    );
  end

  // Counting next-state valids keeps the registered count in step with the stages.
  always_comb cnt_d = count_valid(nxt_valid);

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign lsu_pipe_cnt  = cnt_q;
  assign lsu_pipe_idle = (cnt_q == '0) && !lsu_p.valid;

  assign lsu_pkt_dc1  = stg_pkt[0];
  assign lsu_pkt_dc2  = stg_pkt[1];
  assign lsu_pkt_dc3  = stg_pkt[2];
  assign lsu_pkt_dc4  = stg_pkt[3];
  assign lsu_pkt_dc5  = stg_pkt[4];
  assign lsu_addr_dc1 = stg_addr[0];
  assign lsu_addr_dc2 = stg_addr[1];
  assign lsu_addr_dc3 = stg_addr[2];
  assign lsu_addr_dc4 = stg_addr[3];
  assign lsu_addr_dc5 = stg_addr[4];

  // Decode never issues alongside DMA; if it does, the decode packet is lost.
  a_dma_lsu_excl: assert property (@(posedge clk) disable iff (rst) !(dma_sel && lsu_p.valid));

endmodule
